// File: rtl/dlx_pw_pkg.sv
// Shared encodings for the parametrised multicycle DLX datapath:
// ALU functions, shifter modes, write-select codes and register load-enable bits.
package dlx_pw_pkg;

  typedef enum logic [2:0] {
    ALUF_ADD = 3'd0,
    ALUF_SUB = 3'd1,
    ALUF_AND = 3'd2,
    ALUF_OR  = 3'd3,
    ALUF_XOR = 3'd4,
    ALUF_SLT = 3'd5,
    ALUF_SEQ = 3'd6,
    ALUF_SNE = 3'd7
  } aluf_e;

  typedef enum logic [1:0] {
    SH_SLL = 2'd0,
    SH_SRL = 2'd1,
    SH_SRA = 2'd2,
    SH_ROR = 2'd3
  } sh_mode_e;

  typedef enum logic [1:0] {
    WSEL_DEC   = 2'd0,
    WSEL_SPEC0 = 2'd1,
    WSEL_SPEC1 = 2'd2,
    WSEL_NONE  = 2'd3
  } wsel_e;

  typedef enum logic [1:0] {
    S1_PC  = 2'd0,
    S1_A   = 2'd1,
    S1_B   = 2'd2,
    S1_MDR = 2'd3
  } s1_sel_e;

  typedef enum logic [1:0] {
    S2_B    = 2'd0,
    S2_IMM  = 2'd1,
    S2_ZERO = 2'd2,
    S2_ONE  = 2'd3
  } s2_sel_e;

  typedef enum logic [1:0] {
    AOVR_IR   = 2'd0,
    AOVR_ADD  = 2'd1,
    AOVR_TEST = 2'd2
  } aluf_ovr_e;

  localparam int RE_PC  = 0;
  localparam int RE_MAR = 1;
  localparam int RE_MDR = 2;
  localparam int RE_C   = 3;
  localparam int RE_B   = 4;
  localparam int RE_A   = 5;
  localparam int RE_IR  = 6;

  function automatic logic is_rtype(input logic [5:0] opcode);
    return opcode == 6'd0;
  endfunction

endpackage

// File: rtl/dlx_iter_shifter.sv
// Iterative one-bit-per-cycle shifter with start/busy/done handshake;
// the result stays on the output until the next accepted start.
module dlx_iter_shifter
  import dlx_pw_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [DW-1:0]         opnd,
  input  logic [$clog2(DW)-1:0] shamt,
  output logic [DW-1:0]         result,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {SH_IDLE, SH_RUN, SH_DONE} sh_state_e;

  sh_state_e             state;
  logic [$clog2(DW)-1:0] cnt;
  logic [1:0]            mode_q;
  logic [DW-1:0]         val;

  function automatic logic [DW-1:0] shift1(input logic [DW-1:0] v, input logic [1:0] m);
    case (m)
      SH_SLL:  shift1 = {v[DW-2:0], 1'b0};
      SH_SRL:  shift1 = {1'b0, v[DW-1:1]};
      SH_SRA:  shift1 = {v[DW-1], v[DW-1:1]};
      default: shift1 = {v[0], v[DW-1:1]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= SH_IDLE;
      cnt    <= '0;
      mode_q <= SH_SLL;
      val    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        SH_IDLE: begin
          if (start) begin
            val    <= opnd;
            cnt    <= shamt;
            mode_q <= mode;
            busy   <= 1'b1;
            state  <= SH_RUN;
          end
        end
        SH_RUN: begin
          if (cnt == '0) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= SH_DONE;
          end else begin
            val <= shift1(val, mode_q);
            cnt <= cnt - 1'b1;
          end
        end
        SH_DONE: begin
          done  <= 1'b0;
          state <= SH_IDLE;
        end
        default: state <= SH_IDLE;
      endcase
    end
  end

  assign result = val;

endmodule

// File: rtl/dlx_datapath_pw.sv
// Parametrised multicycle DLX datapath: GPR file, A/B/C/MDR/MAR/PC/IR registers,
// ALU, iterative shifter, address window and LL/SC reservation with snoop.
module dlx_datapath_pw
  import dlx_pw_pkg::*;
#(
  parameter int DW    = 32,
  parameter int NREG  = 32,
  parameter int AW    = 24,
  parameter int SPEC0 = 29,
  parameter int SPEC1 = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [6:0]    reg_en,
  input  logic [1:0]    s1_sel,
  input  logic [1:0]    s2_sel,
  input  logic [1:0]    aluf_ovr,
  input  logic          dint_sel,
  input  logic          mdr_sel,
  input  logic          amux_sel,
  input  logic          gpr_we,
  input  logic [1:0]    wsel,
  input  logic          sh_start,
  input  logic [1:0]    sh_mode,
  input  logic          ll_set,
  input  logic          snoop_wr,
  input  logic [AW-1:0] snoop_adr,
  input  logic [4:0]    d_adr,
  input  logic [DW-1:0] DI,
  output logic [DW-1:0] IR,
  output logic [DW-1:0] DO,
  output logic [DW-1:0] AO,
  output logic [DW-1:0] MAR_OUT,
  output logic [DW-1:0] GPR_D,
  output logic          AEQZ,
  output logic          OVF,
  output logic          sh_busy,
  output logic          sh_done,
  output logic          sc_ok
);

  localparam int ADR_W = $clog2(NREG);
  localparam int SW    = $clog2(DW);

  logic [DW-1:0] ir_q, a_q, b_q, c_q, mdr_q, mar_q, pc_q;
  logic [DW-1:0] gpr [NREG];
  logic [AW-1:0] link_adr;
  logic          link_valid;

  function automatic logic [DW-1:0] alu_op(input logic [2:0] f,
                                           input logic signed [DW-1:0] x,
                                           input logic signed [DW-1:0] y);
    case (f)
      ALUF_ADD: alu_op = x + y;
      ALUF_SUB: alu_op = x - y;
      ALUF_AND: alu_op = x & y;
      ALUF_OR:  alu_op = x | y;
      ALUF_XOR: alu_op = x ^ y;
      ALUF_SLT: alu_op = (x < y)  ? DW'(1) : '0;
      ALUF_SEQ: alu_op = (x == y) ? DW'(1) : '0;
      default:  alu_op = (x != y) ? DW'(1) : '0;
    endcase
  endfunction

  // Signed overflow only exists for ADD/SUB; result sign disagrees with operands
  function automatic logic ovf_op(input logic [2:0] f, input logic [DW-1:0] x,
                                  input logic [DW-1:0] y, input logic [DW-1:0] r);
    case (f)
      ALUF_ADD: ovf_op = (x[DW-1] == y[DW-1]) && (r[DW-1] != x[DW-1]);
      ALUF_SUB: ovf_op = (x[DW-1] != y[DW-1]) && (r[DW-1] != x[DW-1]);
      default:  ovf_op = 1'b0;
    endcase
  endfunction

  // Instruction decode; IR is viewed as a 32-bit DLX word regardless of DW
  logic [31:0]             ir_w;
  logic signed [15:0]      imm16;
  logic signed [DW-1:0]    sext_imm;
  logic [4:0]              rd_dec;
  logic [ADR_W-1:0]        rs1_idx, rs2_idx, w_idx;
  logic [2:0]              ir_func, aluf;

  assign ir_w     = 32'(ir_q);
  assign imm16    = ir_w[15:0];
  assign sext_imm = DW'(imm16);
  assign rs1_idx  = ir_w[21 +: ADR_W];
  assign rs2_idx  = ir_w[16 +: ADR_W];
  assign rd_dec   = is_rtype(ir_w[31:26]) ? ir_w[15:11] : ir_w[20:16];
  assign ir_func  = is_rtype(ir_w[31:26]) ? ir_w[2:0] : ir_w[28:26];

  always_comb begin
    aluf = ir_func;
    case (aluf_ovr)
      AOVR_ADD:  aluf = ALUF_ADD;
      AOVR_TEST: aluf = ALUF_SLT;
      default:   aluf = ir_func;
    endcase
  end

  always_comb begin
    w_idx = rd_dec[ADR_W-1:0];
    case (wsel)
      WSEL_SPEC0: w_idx = ADR_W'(SPEC0);
      WSEL_SPEC1: w_idx = ADR_W'(SPEC1);
      default:    w_idx = rd_dec[ADR_W-1:0];
    endcase
  end

  logic signed [DW-1:0] s1_v, s2_v;
  logic [DW-1:0]        alu_res, sh_res, dint, amux;

  always_comb begin
    s1_v = pc_q;
    case (s1_sel)
      S1_A:    s1_v = a_q;
      S1_B:    s1_v = b_q;
      S1_MDR:  s1_v = mdr_q;
      default: s1_v = pc_q;
    endcase
    s2_v = b_q;
    case (s2_sel)
      S2_IMM:  s2_v = sext_imm;
      S2_ZERO: s2_v = '0;
      S2_ONE:  s2_v = DW'(1);
      default: s2_v = b_q;
    endcase
  end

  assign alu_res = alu_op(aluf, s1_v, s2_v);
  assign OVF     = ovf_op(aluf, s1_v, s2_v, alu_res);
  assign dint    = dint_sel ? sh_res : alu_res;
  assign amux    = amux_sel ? mar_q : pc_q;

  dlx_iter_shifter #(.DW(DW)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .start  (sh_start),
    .mode   (sh_mode),
    .opnd   (s1_v),
    .shamt  (s2_v[SW-1:0]),
    .result (sh_res),
    .busy   (sh_busy),
    .done   (sh_done)
  );

  // R0 is never written, so it reads back as zero without a read-side mux
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= '0; a_q <= '0; b_q <= '0; c_q <= '0;
      mdr_q <= '0; mar_q <= '0; pc_q <= '0;
      for (int i = 0; i < NREG; i++) gpr[i] <= '0;
      link_adr   <= '0;
      link_valid <= 1'b0;
    end else begin
      if (reg_en[RE_IR])  ir_q  <= DI;
      if (reg_en[RE_A])   a_q   <= gpr[rs1_idx];
      if (reg_en[RE_B])   b_q   <= gpr[rs2_idx];
      if (reg_en[RE_C])   c_q   <= dint;
      if (reg_en[RE_MDR]) mdr_q <= mdr_sel ? DI : dint;
      if (reg_en[RE_MAR]) mar_q <= dint;
      if (reg_en[RE_PC])  pc_q  <= dint;
      if (gpr_we && (wsel != WSEL_NONE) && (w_idx != '0)) gpr[w_idx] <= c_q;
      if (ll_set) begin
        link_adr   <= mar_q[AW-1:0];
        link_valid <= 1'b1;
      end else if (snoop_wr && (snoop_adr == link_adr)) begin
        link_valid <= 1'b0;
      end
    end
  end

  assign IR      = ir_q;
  assign DO      = mdr_q;
  assign MAR_OUT = mar_q;
  assign AO      = DW'(amux[AW-1:0]);
  assign GPR_D   = gpr[d_adr[ADR_W-1:0]];
  assign AEQZ    = (gpr[rs1_idx] == '0);
  assign sc_ok   = link_valid && (mar_q[AW-1:0] == link_adr);

endmodule

// File: tb/tb_dlx_datapath_pw.sv
// Scoreboard testbench for dlx_datapath_pw: expectations are queued as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_dlx_datapath_pw;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  reg_en;
  logic [1:0]  s1_sel, s2_sel, aluf_ovr, wsel, sh_mode;
  logic        dint_sel, mdr_sel, amux_sel, gpr_we, sh_start, ll_set, snoop_wr;
  logic [23:0] snoop_adr;
  logic [4:0]  d_adr;
  logic [31:0] DI;
  logic [31:0] IR, DO, AO, MAR_OUT, GPR_D;
  logic        AEQZ, OVF, sh_busy, sh_done, sc_ok;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] expv;

  always #5 clk = ~clk;

  dlx_datapath_pw #(.DW(32), .NREG(32), .AW(24), .SPEC0(29), .SPEC1(30)) dut (
    .clk(clk), .reset(reset), .reg_en(reg_en), .s1_sel(s1_sel), .s2_sel(s2_sel),
    .aluf_ovr(aluf_ovr), .dint_sel(dint_sel), .mdr_sel(mdr_sel), .amux_sel(amux_sel),
    .gpr_we(gpr_we), .wsel(wsel), .sh_start(sh_start), .sh_mode(sh_mode),
    .ll_set(ll_set), .snoop_wr(snoop_wr), .snoop_adr(snoop_adr), .d_adr(d_adr),
    .DI(DI), .IR(IR), .DO(DO), .AO(AO), .MAR_OUT(MAR_OUT), .GPR_D(GPR_D),
    .AEQZ(AEQZ), .OVF(OVF), .sh_busy(sh_busy), .sh_done(sh_done), .sc_ok(sc_ok)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    reg_en = '0; s1_sel = '0; s2_sel = '0; aluf_ovr = '0; wsel = '0; sh_mode = '0;
    dint_sel = 0; mdr_sel = 0; amux_sel = 0; gpr_we = 0; sh_start = 0;
    ll_set = 0; snoop_wr = 0; snoop_adr = '0;
  endtask

  task automatic load_mdr(input logic [31:0] v);
    DI = v; mdr_sel = 1; reg_en = 7'b0000100;
    tick(); clr_ctrl();
  endtask

  task automatic load_ir(input logic [31:0] v);
    DI = v; reg_en = 7'b1000000;
    tick(); clr_ctrl();
  endtask

  // MDR + 0 through a forced ADD into the register selected by en_bit
  task automatic move_mdr(input int en_bit);
    s1_sel = 2'b11; s2_sel = 2'b10; aluf_ovr = 2'b01; reg_en = 7'(1 << en_bit);
    tick(); clr_ctrl();
  endtask

  task automatic write_gpr(input int idx, input logic [31:0] v);
    load_ir(32'(idx) << 11);
    load_mdr(v);
    move_mdr(3);
    gpr_we = 1; wsel = 2'b00;
    tick(); clr_ctrl();
  endtask

  task automatic test_reset();
    logic [31:0] obs [10];
    string       nm  [10];
    reset = 1; clr_ctrl(); DI = '0; d_adr = '0;
    tick(); tick();
    reset = 0;
    #1;
    nm = '{"rst_IR", "rst_DO", "rst_AO", "rst_MAR", "rst_GPR_D", "rst_AEQZ",
           "rst_OVF", "rst_busy", "rst_done", "rst_sc_ok"};
    obs = '{IR, DO, AO, MAR_OUT, GPR_D, {31'd0, AEQZ}, {31'd0, OVF},
            {31'd0, sh_busy}, {31'd0, sh_done}, {31'd0, sc_ok}};
    for (int i = 0; i < 10; i++) exp_q.push_back((i == 5) ? 32'd1 : 32'd0);
    for (int i = 0; i < 10; i++) begin
      expv = exp_q.pop_front(); tests++;
      if (obs[i] !== expv) begin
        fails++; $display("FAIL %s got=%h exp=%h", nm[i], obs[i], expv);
      end
    end
  endtask

  task automatic test_pc_window();
    load_mdr(32'h10); move_mdr(0);
    s1_sel = 2'b00; s2_sel = 2'b11; aluf_ovr = 2'b01; reg_en = 7'b0000001;
    exp_q.push_back(32'h11);
    tick(); clr_ctrl(); #1;
    expv = exp_q.pop_front(); tests++;
    if (AO !== expv) begin fails++; $display("FAIL pc_inc AO=%h exp=%h", AO, expv); end

    load_mdr(32'hFF123456); move_mdr(0);
    exp_q.push_back(32'h00123456);
    #1;
    expv = exp_q.pop_front(); tests++;
    if (AO !== expv) begin fails++; $display("FAIL ao_window AO=%h exp=%h", AO, expv); end

    move_mdr(1);
    amux_sel = 1;
    exp_q.push_back(32'h00123456); exp_q.push_back(32'hFF123456);
    #1;
    expv = exp_q.pop_front(); tests++;
    if (AO !== expv) begin fails++; $display("FAIL ao_mar AO=%h exp=%h", AO, expv); end
    expv = exp_q.pop_front(); tests++;
    if (MAR_OUT !== expv) begin fails++; $display("FAIL mar_out got=%h exp=%h", MAR_OUT, expv); end
    clr_ctrl();
  endtask

  task automatic test_alu_gpr();
    write_gpr(1, 32'h7FFFFFFF);
    write_gpr(2, 32'h00000001);
    load_ir((32'd1 << 21) | (32'd2 << 16) | (32'd3 << 11));
    exp_q.push_back(32'd0);
    #1;
    expv = exp_q.pop_front(); tests++;
    if ({31'd0, AEQZ} !== expv) begin fails++; $display("FAIL aeqz got=%b exp=%h", AEQZ, expv); end

    reg_en = 7'b0110000; tick(); clr_ctrl();
    s1_sel = 2'b01; s2_sel = 2'b00; reg_en = 7'b0001000;
    exp_q.push_back(32'd1);
    #1;
    expv = exp_q.pop_front(); tests++;
    if ({31'd0, OVF} !== expv) begin fails++; $display("FAIL add_ovf got=%b exp=%h", OVF, expv); end
    tick(); clr_ctrl();
    gpr_we = 1; wsel = 2'b00; tick(); clr_ctrl();
    d_adr = 5'd3;
    exp_q.push_back(32'h80000000);
    #1;
    expv = exp_q.pop_front(); tests++;
    if (GPR_D !== expv) begin fails++; $display("FAIL add_wb R3=%h exp=%h", GPR_D, expv); end

    write_gpr(0, 32'h1234);
    d_adr = 5'd0;
    exp_q.push_back(32'd0);
    #1;
    expv = exp_q.pop_front(); tests++;
    if (GPR_D !== expv) begin fails++; $display("FAIL r0_write R0=%h exp=%h", GPR_D, expv); end
  endtask

  task automatic run_shift(input logic [31:0] opnd, input logic [1:0] s2, input logic [1:0] mode,
                           input int shamt, input logic [31:0] result, input string nm);
    load_mdr(opnd);
    s1_sel = 2'b11; s2_sel = s2; sh_mode = mode; sh_start = 1;
    tick();
    sh_start = 0;
    for (int i = 0; i < shamt + 1; i++) exp_q.push_back(32'b10);
    exp_q.push_back(32'b01);
    exp_q.push_back(32'b00);
    for (int i = 0; i < shamt + 3; i++) begin
      expv = exp_q.pop_front(); tests++;
      if ({30'd0, sh_busy, sh_done} !== expv) begin
        fails++; $display("FAIL %s_hs cyc=%0d busy_done=%b%b exp=%b", nm, i + 1, sh_busy, sh_done, expv[1:0]);
      end
      // extra starts while RUN and during DONE must be ignored
      sh_start = (i == 1) || (i == shamt + 1);
      sh_mode  = 2'b00;
      tick();
    end
    clr_ctrl();
    dint_sel = 1; reg_en = 7'b0000010;
    exp_q.push_back(result);
    tick(); clr_ctrl();
    expv = exp_q.pop_front(); tests++;
    if (MAR_OUT !== expv) begin fails++; $display("FAIL %s_res got=%h exp=%h", nm, MAR_OUT, expv); end
  endtask

  task automatic test_shifter();
    load_ir(32'h04000004);
    run_shift(32'h80000010, 2'b01, 2'b10, 4, 32'hF8000001, "sra4");
    run_shift(32'h12345678, 2'b10, 2'b00, 0, 32'h12345678, "shamt0");
    run_shift(32'h00000001, 2'b11, 2'b11, 1, 32'h80000000, "ror1");
    run_shift(32'h80000001, 2'b11, 2'b01, 1, 32'h40000000, "srl1");
  endtask

  task automatic test_shift_reset();
    load_mdr(32'h0000000F);
    s1_sel = 2'b11; s2_sel = 2'b01; sh_mode = 2'b00; sh_start = 1;
    tick(); clr_ctrl();
    tick();
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 6; i++) exp_q.push_back(32'b00);
    for (int i = 0; i < 6; i++) begin
      expv = exp_q.pop_front(); tests++;
      if ({30'd0, sh_busy, sh_done} !== expv) begin
        fails++; $display("FAIL rst_shift cyc=%0d busy_done=%b%b exp=%b", i, sh_busy, sh_done, expv[1:0]);
      end
      tick();
    end
    dint_sel = 1; reg_en = 7'b0000010;
    exp_q.push_back(32'd0);
    tick(); clr_ctrl();
    expv = exp_q.pop_front(); tests++;
    if (MAR_OUT !== expv) begin fails++; $display("FAIL rst_shift_res got=%h exp=%h", MAR_OUT, expv); end
  endtask

  task automatic test_reservation();
    logic exp_ok [5];
    load_mdr(32'h400); move_mdr(1);
    exp_ok = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int step = 0; step < 5; step++) begin
      case (step)
        1: ll_set = 1;
        2: begin snoop_wr = 1; snoop_adr = 24'h404; end
        3: begin snoop_wr = 1; snoop_adr = 24'h400; end
        4: begin ll_set = 1; snoop_wr = 1; snoop_adr = 24'h400; end
        default: ;
      endcase
      exp_q.push_back({31'd0, exp_ok[step]});
      tick(); clr_ctrl(); #1;
      expv = exp_q.pop_front(); tests++;
      if ({31'd0, sc_ok} !== expv) begin
        fails++; $display("FAIL sc_ok step=%0d got=%b exp=%h", step, sc_ok, expv);
      end
    end
    load_mdr(32'h404); move_mdr(1);
    exp_q.push_back(32'd0);
    #1;
    expv = exp_q.pop_front(); tests++;
    if ({31'd0, sc_ok} !== expv) begin fails++; $display("FAIL sc_ok_mar got=%b exp=%h", sc_ok, expv); end
  endtask

  task automatic test_back_to_back_wsel();
    logic [31:0] obs [4];
    load_ir(32'd5 << 11);
    load_mdr(32'hABCD); move_mdr(3);
    gpr_we = 1; wsel = 2'b01; tick(); clr_ctrl();
    load_mdr(32'h5555); move_mdr(3);
    gpr_we = 1; wsel = 2'b11; tick(); clr_ctrl();
    exp_q.push_back(32'hABCD); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    d_adr = 5'd29; #1; obs[0] = GPR_D;
    d_adr = 5'd5;  #1; obs[1] = GPR_D;
    d_adr = 5'd30; #1; obs[2] = GPR_D;
    gpr_we = 1; wsel = 2'b10; tick(); clr_ctrl();
    exp_q.push_back(32'h5555);
    #1; obs[3] = GPR_D;
    for (int i = 0; i < 4; i++) begin
      expv = exp_q.pop_front(); tests++;
      if (obs[i] !== expv) begin fails++; $display("FAIL wsel_%0d got=%h exp=%h", i, obs[i], expv); end
    end
  endtask

  initial begin
    reset = 1; clr_ctrl(); DI = '0; d_adr = '0;
    test_reset();
    test_pc_window();
    test_alu_gpr();
    test_shifter();
    test_shift_reset();
    test_reservation();
    test_back_to_back_wsel();
    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dlx_datapath_pw.md
Name: dlx_datapath_pw

Overview:
Parametrised next-generation multicycle DLX datapath for the dual-core system: register file, A/B/C/MDR/MAR/PC/IR registers, ALU, and address window, all generalised in data width, register count and address window.
- Adds an iterative multi-mode shifter with a start/busy/done handshake.
- Adds an LL/SC reservation register with cross-core snoop invalidation.
- Sits between the per-core control FSM and the shared memory arbiter.

Parameters:
DW, 32, datapath width (>=16)
NREG, 32, GPR count (power of 2, <=32); ADR_W = clog2(NREG)
AW, 24, address window bits passed to AO; upper DW-AW bits forced 0
SPEC0, 29, GPR index selected by wsel=01
SPEC1, 30, GPR index selected by wsel=10

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
reg_en  in  7  load enables {IR,A,B,C,MDR,MAR,PC}, bit6=IR
s1_sel  in  2  S1 operand: 00 PC, 01 A, 10 B, 11 MDR
s2_sel  in  2  S2 operand: 00 B, 01 sext_imm, 10 zero, 11 one
aluf_ovr  in  2  00 IR function, 01 force ADD, 10 force test (compare)
dint_sel  in  1  C/PC/MAR/MDR source: 0 ALU, 1 shifter result
mdr_sel  in  1  MDR source: 0 DINT, 1 DI
amux_sel  in  1  AO source: 0 PC, 1 MAR
gpr_we  in  1  GPR write of C
wsel  in  2  write address: 00 decoded, 01 SPEC0, 10 SPEC1, 11 discard
sh_start  in  1  start shift pulse
sh_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR
ll_set  in  1  capture MAR as reservation
snoop_wr  in  1  other core wrote snoop_adr
snoop_adr  in  AW  address written by other core
d_adr  in  5  debug read port address
DI  in  DW  memory read data
IR  out  DW  instruction register
DO  out  DW  MDR
AO  out  DW  memory address, zero-extended from AW bits
MAR_OUT  out  DW  MAR
GPR_D  out  DW  debug read data
AEQZ  out  1  GPR A read port == 0
OVF  out  1  signed overflow of ADD/SUB
sh_busy  out  1  shifter active
sh_done  out  1  one-cycle completion pulse
sc_ok  out  1  reservation valid and matches MAR[AW-1:0]

Behaviour:
- Reset (sync): IR, A, B, C, MDR, MAR, PC, GPR array, shifter state, and link_valid/link_adr all clear to 0. Outputs then: IR=DO=AO=MAR_OUT=0, GPR_D=0, AEQZ=1, OVF=0, sh_busy=0, sh_done=0, sc_ok=0.
- Decode (combinational from IR):
  - rs1 = IR[25:21], rs2 = IR[20:16].
  - Write address = IR[15:11] when opcode IR[31:26]==0, else IR[20:16]; GPR index uses the low ADR_W bits.
  - sext_imm = IR[15:0] sign-extended to DW.
  - ALU function = IR[2:0] for R-type, IR[28:26] otherwise.
- GPR: two async read ports plus debug port d_adr; R0 reads 0 and writes to R0 are dropped. A write is visible to reads on the next cycle (no bypass). wsel=11 suppresses the write.
- ALU: 1-cycle combinational. DW-bit wrap-around. OVF asserts only for ADD/SUB signed overflow, else 0. Test mode yields DW'(1) or 0.
- Registers: each loads on its reg_en bit at the clock edge; otherwise it holds.
- Shifter FSM (IDLE, RUN, DONE):
  - IDLE + sh_start: latch operand S1, shamt = S2[clog2(DW)-1:0], mode; go to RUN (sh_busy=1).
  - RUN: one bit position per cycle, decrementing shamt. At shamt==0 go to DONE.
  - DONE: sh_done=1 for exactly one cycle, result held on the shifter output until the next start; return to IDLE.
  - Latency is shamt+2 cycles from sh_start to sh_done; shamt=0 gives sh_done 2 cycles later with the operand unchanged.
  - sh_start while busy/DONE is ignored.
  - SRA replicates the MSB; ROR wraps LSB into MSB.
  - Reset mid-shift returns to IDLE, result cleared.
- Reservation:
  - ll_set: link_adr = MAR[AW-1:0], link_valid = 1.
  - snoop_wr with snoop_adr == link_adr clears link_valid.
  - Same-cycle ll_set and snoop_wr: ll_set wins.
  - sc_ok is combinational: link_valid && MAR[AW-1:0] == link_adr.
  - Control clears the reservation via ll_set of an unused address or reset.
- AO = {0, amux[AW-1:0]}.

Decomposition:
Package dlx_pw_pkg holds ALUF codes (ADD, SUB, AND, OR, XOR, SLT, SEQ, SNE), sh_mode codes, wsel codes, reg_en bit positions, and the s1/s2 select encodings. Sub-module dlx_iter_shifter contains the shifter FSM and handshake; the ALU and GPR remain inline.

Test Plan:
1. Reset, then load PC=0x10 via s1=PC, s2=one, force ADD, PC en -> PC=0x11, AO=0x11; with AW=24, PC=0xFF123456 gives AO=0x00123456.
2. R-type ADD with A=0x7FFFFFFF, B=1, gpr_we, wsel=00 -> OVF=1, C=0x80000000 written to IR[15:11]; write to R0 -> read still 0.
3. sh_start SRA, operand 0x80000010, shamt=4 -> sh_busy 5 cycles, sh_done on cycle 6, result 0xF8000001; shamt=0 -> done after 2 cycles, unchanged; second start while busy ignored.
4. ROR 0x00000001 by 1 -> 0x80000000; reset asserted mid-RUN -> sh_busy=0 next cycle, no sh_done.
5. MAR=0x400, ll_set -> sc_ok=1; snoop_wr 0x404 -> sc_ok stays 1; snoop_wr 0x400 -> sc_ok=0; simultaneous ll_set and snoop_wr 0x400 -> sc_ok=1.
6. wsel=01 with gpr_we, C=0xABCD -> R29=0xABCD via GPR_D (d_adr=29); wsel=11 -> no register changes.
